// File: rtl/dat_copy_master_pkg.sv
// Shared definitions for Kestrel-2 data-bus initiators.
//   ADR_W   : number of word-address bits on the data bus (byte bit 0 is implied)
//   state_t : copy-engine FSM encoding (IDLE=0, RD=1, WR=2)
package dat_copy_master_pkg;

  localparam int ADR_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

endpackage

// File: rtl/dat_copy_master_bus_watchdog.sv
// bus_watchdog: transaction timeout counter shared by bus initiators.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : restart the count (takes priority over enable)
//   enable   : count one more cycle spent waiting for an acknowledge
//   expire   : count has reached its last tick; an enabled cycle without an
//              acknowledge now is the TIMEOUT-th waiting cycle
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // The count only ever runs 0..TIMEOUT-1; the owner times out on the last
  // tick, so no saturation logic is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dat_copy_master.sv
// dat_copy_master: copies len_i 16-bit words from src_i to dst_i on the
// Kestrel-2 data bus using the strobe/acknowledge handshake.
//   dat_clk_i, dat_rst_i          : clock, asynchronous active-high reset
//   src_i, dst_i, len_i, go_i     : copy request, sampled when go_i is accepted
//   busy_o, done_o, err_o         : status (done_o pulses on finish or abort,
//                                   err_o is a sticky timeout flag)
//   dat_adr_o, dat_dat_o, dat_we_o,
//   dat_stb_o                     : registered bus request
//   dat_dat_i, dat_ack_i          : responder read data and acknowledge
module dat_copy_master
  import dat_copy_master_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             dat_clk_i,
  input  logic             dat_rst_i,
  input  logic [15:1]      src_i,
  input  logic [15:1]      dst_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             go_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [15:1]      dat_adr_o,
  output logic [15:0]      dat_dat_o,
  input  logic [15:0]      dat_dat_i,
  output logic             dat_we_o,
  output logic             dat_stb_o,
  input  logic             dat_ack_i
);

  state_t           state, state_next;
  logic [ADR_W-1:0] src, src_next;
  logic [ADR_W-1:0] dst, dst_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic [15:0]      hold, hold_next;
  logic             done_next, err_next;
  logic             wd_clear, wd_enable, wd_expire;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (dat_clk_i),
    .rst    (dat_rst_i),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Next-state logic. Every transition into RD or WR restarts the watchdog,
  // and an acknowledge always wins over a timeout on the same edge.
  always_comb begin
    state_next     = state;
    src_next       = src;
    dst_next       = dst;
    remaining_next = remaining;
    hold_next      = hold;
    done_next      = 1'b0;
    err_next       = err_o;
    wd_clear       = 1'b0;
    wd_enable      = 1'b0;

    case (state)
      IDLE: begin
        if (go_i) begin
          src_next       = src_i;
          dst_next       = dst_i;
          remaining_next = len_i;
          err_next       = 1'b0;
          wd_clear       = 1'b1;
          if (len_i == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RD;
          end
        end
      end

      RD: begin
        if (dat_ack_i) begin
          hold_next  = dat_dat_i;
          src_next   = src + 1'b1;
          state_next = WR;
          wd_clear   = 1'b1;
        end else if (wd_expire) begin
          state_next = IDLE;
          err_next   = 1'b1;
          done_next  = 1'b1;
          wd_clear   = 1'b1;
        end else begin
          wd_enable = 1'b1;
        end
      end

      WR: begin
        if (dat_ack_i) begin
          dst_next       = dst + 1'b1;
          remaining_next = remaining - 1'b1;
          wd_clear       = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = RD;
          end
        end else if (wd_expire) begin
          state_next = IDLE;
          err_next   = 1'b1;
          done_next  = 1'b1;
          wd_clear   = 1'b1;
        end else begin
          wd_enable = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus outputs are flops loaded from next-state values so that they change
  // together with the state and never follow an input combinationally.
  always_ff @(posedge dat_clk_i or posedge dat_rst_i) begin
    if (dat_rst_i) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      hold      <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      dat_stb_o <= 1'b0;
      dat_we_o  <= 1'b0;
      dat_adr_o <= '0;
      dat_dat_o <= '0;
    end else begin
      state     <= state_next;
      src       <= src_next;
      dst       <= dst_next;
      remaining <= remaining_next;
      hold      <= hold_next;
      busy_o    <= (state_next != IDLE);
      done_o    <= done_next;
      err_o     <= err_next;
      dat_stb_o <= (state_next != IDLE);
      dat_we_o  <= (state_next == WR);
      dat_adr_o <= (state_next == WR) ? dst_next : src_next;
      dat_dat_o <= hold_next;
    end
  end

endmodule
